// File: rtl/atari_2000_pkg.sv
// Shared definitions for the atari_2000 video RAM path.
// Grant-state encoding and default RAM geometry.
package atari_2000_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VID  = 2'd1,
        ST_CPU  = 2'd2
    } gnt_state_t;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video has priority, CPU is protected
// from starvation by a saturating counter of consecutive video wins.
module vram_arbiter
    import atari_2000_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_ack,
    output logic [DATA_WIDTH-1:0] vid_rdata,
    output logic                  vid_rvalid,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_rvalid,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  cpu_starved
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    gnt_state_t    state, state_d;
    logic [CW-1:0] starve_cnt, starve_cnt_d;
    logic          rd_vid, rd_cpu;

    assign cpu_starved = (starve_cnt == CW'(STARVE_LIMIT));

    always_comb begin
        vid_ack      = 1'b0;
        cpu_ack      = 1'b0;
        state_d      = ST_IDLE;
        starve_cnt_d = starve_cnt;
        if (reset) begin
            priority case (1'b1)
                cpu_req && (!vid_req || cpu_starved): begin
                    cpu_ack = 1'b1;
                    state_d = ST_CPU;
                end
                vid_req: begin
                    vid_ack = 1'b1;
                    state_d = ST_VID;
                end
                default: ;
            endcase
        end
        if (!cpu_req || cpu_ack)
            starve_cnt_d = '0;
        else if (vid_ack && !cpu_starved)
            starve_cnt_d = starve_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_d;
            starve_cnt <= starve_cnt_d;
        end
    end

    // RAM request stage: one cycle after the accept edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_en <= vid_ack | cpu_ack;
            ram_we <= 1'b0;
            if (cpu_ack) begin
                ram_we    <= cpu_we;
                ram_addr  <= cpu_addr;
                ram_wdata <= cpu_wdata;
            end else if (vid_ack) begin
                ram_addr  <= vid_addr;
            end
        end
    end

    // state names the owner of the access now on the RAM port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_vid     <= 1'b0;
            rd_cpu     <= 1'b0;
            vid_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
            vid_rdata  <= '0;
            cpu_rdata  <= '0;
        end else begin
            rd_vid     <= (state == ST_VID) && !ram_we;
            rd_cpu     <= (state == ST_CPU) && !ram_we;
            vid_rvalid <= rd_vid;
            cpu_rvalid <= rd_cpu;
            if (rd_vid)
                vid_rdata <= ram_rdata;
            if (rd_cpu)
                cpu_rdata <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a behavioural 1-cycle RAM.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        vid_req = 1'b0;
    logic [11:0] vid_addr = '0;
    logic        vid_ack;
    logic [7:0]  vid_rdata;
    logic        vid_rvalid;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic        ram_en;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = '0;
    logic        cpu_starved;

    vram_arbiter #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(8),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vid_req(vid_req),
        .vid_addr(vid_addr),
        .vid_ack(vid_ack),
        .vid_rdata(vid_rdata),
        .vid_rvalid(vid_rvalid),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .ram_en(ram_en),
        .ram_we(ram_we),
        .ram_addr(ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .cpu_starved(cpu_starved)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [4096];
    logic [7:0] shadow [4096];

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we)
                ram[ram_addr] <= ram_wdata;
            else
                ram_rdata <= ram[ram_addr];
        end
    end

    typedef struct {
        int         cyc;
        logic [11:0] addr;
        logic        we;
        logic [7:0]  d;
    } ram_e_t;

    typedef struct {
        int        cyc;
        logic [7:0] d;
    } rd_e_t;

    ram_e_t ram_q[$];
    rd_e_t  vid_q[$];
    rd_e_t  cpu_q[$];

    int cyc = 0;
    int vectors = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string n, int act, int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (ram_en) begin
            if (ram_q.size() == 0) begin
                chk("ram_en_unexpected", 1, 0);
            end else begin
                ram_e_t e;
                e = ram_q.pop_front();
                chk("ram_cycle", cyc, e.cyc);
                chk("ram_addr", int'(ram_addr), int'(e.addr));
                chk("ram_we", int'(ram_we), int'(e.we));
                if (e.we)
                    chk("ram_wdata", int'(ram_wdata), int'(e.d));
            end
        end
        if (vid_rvalid) begin
            if (vid_q.size() == 0) begin
                chk("vid_rvalid_unexpected", 1, 0);
            end else begin
                rd_e_t e;
                e = vid_q.pop_front();
                chk("vid_rvalid_cycle", cyc, e.cyc);
                chk("vid_rdata", int'(vid_rdata), int'(e.d));
            end
        end
        if (cpu_rvalid) begin
            if (cpu_q.size() == 0) begin
                chk("cpu_rvalid_unexpected", 1, 0);
            end else begin
                rd_e_t e;
                e = cpu_q.pop_front();
                chk("cpu_rvalid_cycle", cyc, e.cyc);
                chk("cpu_rdata", int'(cpu_rdata), int'(e.d));
            end
        end
    end

    // g: 0 none, 1 video, 2 cpu; st: expected cpu_starved or -1
    task automatic step(int g, int st = -1, bit pr = 1'b1, bit pd = 1'b1);
        @(negedge clk);
        chk("vid_ack", int'(vid_ack), int'(g == 1));
        chk("cpu_ack", int'(cpu_ack), int'(g == 2));
        if (st >= 0)
            chk("cpu_starved", int'(cpu_starved), st);
        if (g == 1) begin
            if (pr) ram_q.push_back('{cyc + 1, vid_addr, 1'b0, 8'h00});
            if (pd) vid_q.push_back('{cyc + 3, shadow[vid_addr]});
        end else if (g == 2) begin
            if (pr) ram_q.push_back('{cyc + 1, cpu_addr, cpu_we, cpu_wdata});
            if (cpu_we)
                shadow[cpu_addr] = cpu_wdata;
            else if (pd)
                cpu_q.push_back('{cyc + 3, shadow[cpu_addr]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset();
        @(negedge clk);
        chk("rst_vid_ack", int'(vid_ack), 0);
        chk("rst_cpu_ack", int'(cpu_ack), 0);
        chk("rst_ram_en", int'(ram_en), 0);
        chk("rst_ram_we", int'(ram_we), 0);
        chk("rst_ram_addr", int'(ram_addr), 0);
        chk("rst_ram_wdata", int'(ram_wdata), 0);
        chk("rst_vid_rvalid", int'(vid_rvalid), 0);
        chk("rst_cpu_rvalid", int'(cpu_rvalid), 0);
        chk("rst_vid_rdata", int'(vid_rdata), 0);
        chk("rst_cpu_rdata", int'(cpu_rdata), 0);
        chk("rst_cpu_starved", int'(cpu_starved), 0);
    endtask

    task automatic idle(int n);
        vid_req = 1'b0;
        cpu_req = 1'b0;
        for (int i = 0; i < n; i++) step(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i]    = 8'((i * 7) + 3);
            shadow[i] = 8'((i * 7) + 3);
        end
        ram[12'h010]    = 8'h5A;
        shadow[12'h010] = 8'h5A;

        // reset with both requests asserted
        reset   = 1'b0;
        vid_req = 1'b1;
        cpu_req = 1'b1;
        chk_reset();
        chk_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // video-only read
        cpu_req  = 1'b0;
        vid_addr = 12'h010;
        step(1, 0);
        idle(4);

        // streaming video reads
        vid_req = 1'b1;
        for (int a = 0; a < 16; a++) begin
            vid_addr = 12'(a);
            step(1);
        end
        idle(4);

        // cpu write then read of same address
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 12'h123;
        cpu_wdata = 8'hA5;
        step(2);
        cpu_we = 1'b0;
        step(2);
        idle(4);

        // sustained contention
        vid_req  = 1'b1;
        cpu_req  = 1'b1;
        vid_addr = 12'h300;
        cpu_addr = 12'h200;
        for (int r = 0; r < 2; r++) begin
            for (int v = 0; v < 4; v++) step(1, 0);
            step(2, 1);
        end
        idle(4);

        // counter clears when cpu_req drops
        vid_req  = 1'b1;
        cpu_req  = 1'b1;
        vid_addr = 12'h301;
        cpu_addr = 12'h201;
        step(1, 0);
        step(1, 0);
        cpu_req = 1'b0;
        step(1, 0);
        cpu_req = 1'b1;
        for (int v = 0; v < 4; v++) step(1, 0);
        step(2, 1);
        idle(4);

        // reset after a video accept discards in-flight reads
        vid_req  = 1'b1;
        cpu_req  = 1'b1;
        vid_addr = 12'h020;
        cpu_addr = 12'h040;
        step(1, 0, 1'b1, 1'b0);
        step(1, 0, 1'b0, 1'b0);
        reset = 1'b0;
        chk_reset();
        chk_reset();
        @(posedge clk);
        #1;
        reset   = 1'b1;
        vid_req = 1'b0;
        cpu_req = 1'b0;
        idle(4);
        vid_req = 1'b1;
        cpu_req = 1'b1;
        for (int v = 0; v < 4; v++) step(1, 0);
        step(2, 1);
        idle(6);

        chk("ram_q_drained", ram_q.size(), 0);
        chk("vid_q_drained", vid_q.size(), 0);
        chk("cpu_q_drained", cpu_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: video RAM word address width.
REQ-002 Parameter DATA_WIDTH, default 8: video RAM word width.
REQ-003 Parameter STARVE_LIMIT, default 4: the maximum number of consecutive video grants while a CPU request waits.
REQ-004 Port clk, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-005 Port reset, input, 1: the reset; it SHALL be asynchronous and active-low.
REQ-006 Video requester ports SHALL be: vid_req in 1, vid_addr in ADDR_WIDTH, vid_ack out 1, vid_rdata out DATA_WIDTH, vid_rvalid out 1.
REQ-007 CPU requester ports SHALL be: cpu_req in 1, cpu_we in 1, cpu_addr in ADDR_WIDTH, cpu_wdata in DATA_WIDTH, cpu_ack out 1, cpu_rdata out DATA_WIDTH, cpu_rvalid out 1.
REQ-008 RAM ports SHALL be: ram_en out 1, ram_we out 1, ram_addr out ADDR_WIDTH, ram_wdata out DATA_WIDTH, ram_rdata in DATA_WIDTH. The RAM SHALL be single-port with 1-cycle read latency.
REQ-009 Port cpu_starved, out 1: SHALL be high while the starvation counter equals STARVE_LIMIT.

Function
REQ-010 At most one grant SHALL be given per cycle.
REQ-011 vid_ack and cpu_ack SHALL be combinational and never high together.
REQ-012 A transfer SHALL occur on the edge where req && ack is high.
REQ-013 Requesters SHALL hold req, addr, we and wdata stable until ack is seen.
REQ-014 Grant rule, video request only: vid_req=1 and cpu_req=0 SHALL grant video.
REQ-015 Grant rule, CPU request only: cpu_req=1 and vid_req=0 SHALL grant the CPU.
REQ-016 Grant rule, both requesting: video SHALL win unless the starvation counter equals STARVE_LIMIT, in which case the CPU SHALL win.
REQ-017 The starvation counter SHALL increment, saturating at STARVE_LIMIT, on each video grant while cpu_req=1.
REQ-018 The starvation counter SHALL clear on a CPU grant, or in any cycle with cpu_req=0.
REQ-019 The grant-state register SHALL take one of IDLE, VID or CPU each cycle, recording the source of the transfer accepted on the last edge.
REQ-020 State transitions: IDLE to VID/CPU per REQ-014..016; VID to CPU per REQ-016; CPU to VID or CPU per REQ-014..016; any state to IDLE when no request is present.
REQ-021 RAM drive: the cycle after an accept edge SHALL carry registered ram_en=1, ram_addr/ram_we/ram_wdata from the accepted requester; video accepts always drive ram_we=0.
REQ-022 Read return: rdata SHALL be registered from ram_rdata, with the matching rvalid high for exactly 1 cycle, 2 cycles after the accept edge.
REQ-023 Back-to-back accepts SHALL give back-to-back rvalid pulses; throughput SHALL be 1 access per cycle.
REQ-024 CPU writes SHALL produce no cpu_rvalid.
REQ-025 A write followed next cycle by a read of the same address SHALL return the new data.
REQ-026 rdata SHALL hold its last value when rvalid=0.
REQ-027 Address width: addresses SHALL be passed unmodified, with no wrap logic; the caller owns the range.
REQ-028 When no request is present, ram_en SHALL be 0 in the following cycle, and ram_addr/ram_wdata SHALL hold their previous values.

Reset
REQ-029 While reset=0, all of these SHALL be 0: ram_en, ram_we, ram_addr, ram_wdata, vid_rvalid, cpu_rvalid, vid_rdata, cpu_rdata, cpu_starved, the starvation counter, and the pipeline tag registers; the state SHALL be IDLE.
REQ-030 Acks SHALL be 0 while reset=0, regardless of req.
REQ-031 Reset asserted mid-operation SHALL discard in-flight accesses; no rvalid SHALL be emitted for them after release.
REQ-032 The first grant after reset release SHALL follow REQ-014..016 with the counter at 0.

Structure
REQ-033 Shared package atari_2000_pkg SHALL hold the state encoding (IDLE/VID/CPU) and the default ADDR_WIDTH/DATA_WIDTH constants.
REQ-034 The block SHALL be a single module with no sub-module.
REQ-035 The RAM SHALL be instantiated by the parent, next to the video scanout and micro86.

Verification
REQ-036 Video-only read: vid_req=1, vid_addr=0x010, RAM[0x010]=0x5A -> vid_ack same cycle; ram_en/ram_addr=0x010 the next cycle; vid_rvalid=1 with vid_rdata=0x5A 2 cycles after accept.
REQ-037 Contention: vid_req=1 and cpu_req=1 continuously, STARVE_LIMIT=4 -> grant order V,V,V,V,C,V,V,V,V,C; cpu_starved=1 in each cycle before a C.
REQ-038 CPU write then read: cpu_we=1 writes 0xA5 to 0x123, then a read of 0x123 -> cpu_rvalid only for the read, with cpu_rdata=0xA5 and no rvalid for the write.
REQ-039 Streaming: video reads 0x000..0x00F on consecutive cycles, CPU idle -> 16 consecutive vid_rvalid pulses with data in address order.
REQ-040 Reset mid-flight: reset=0 in the cycle after a video accept -> no vid_rvalid after release; all outputs 0; the next grant behaves per REQ-032.
REQ-041 Counter clear: cpu_req drops after 2 video grants, then re-asserts -> the counter restarts at 0, giving 4 video grants before the next CPU grant.
